mult_div_unit: RTL
==================

# mult_div_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, serving MIPS R-type MULT, MULTU, DIV, DIVU, MTHI and MTLO beside the combinational ALU. It accepts one operation per START handshake, iterates one bit per cycle, and signals completion with a one-cycle DONE pulse. The pipeline stalls on BUSY before issuing any MFHI/MFLO.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- CLK  in  1  rising-edge clock.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  request; sampled only in IDLE.
- FUNC  in  6  R-type function code selecting the operation.
- RS_VAL  in  WIDTH  multiplicand or dividend; source for MTHI/MTLO.
- RT_VAL  in  WIDTH  multiplier or divisor.
- BUSY  out  1  operation in flight; new requests are ignored.
- DONE  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
- DIV_ZERO  out  1  last accepted divide had a zero divisor.
- HI  out  WIDTH  high product or remainder.
- LO  out  WIDTH  low product or quotient.

## Operation
- FUNC codes:
  - MULT 011000, MULTU 011001.
  - DIV 011010, DIVU 011011.
  - MTHI 010001, MTLO 010011.
  - Any other code with START is ignored: no state change and no BUSY.
- MTHI/MTLO: with START in IDLE, HI (or LO) takes RS_VAL at the next edge. No BUSY, no DONE.
- States: IDLE, MUL, DIV, FIX.
  - IDLE→MUL or IDLE→DIV on an accepted START with a valid code; operands are captured.
  - MUL/DIV run WIDTH iteration cycles, then go to FIX.
  - FIX→IDLE after one cycle.
- Signed operations iterate on magnitudes, then FIX applies the signs.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Multiply: shift-add into a 2·WIDTH accumulator. HI:LO = the full 2·WIDTH product.
- Divide: restoring, one quotient bit per cycle.
- Overflow (most-negative ÷ −1, signed): result wraps naturally, LO = most-negative, HI = 0. No flag.
- Divide by zero is detected at accept. The unit goes straight to FIX:
  - HI = RS_VAL, LO = all ones.
  - DIV_ZERO = 1.
- DIV_ZERO is cleared on the next accepted MULT/MULTU/DIV/DIVU.
- HI/LO change only in FIX or on MTHI/MTLO. They hold between operations.

## Timing
- Reset (RSTN low, async, any state): state = IDLE; BUSY, DONE, DIV_ZERO, HI and LO all go to 0 immediately.
- Reset mid-operation discards the operation entirely. No DONE follows.
- Accept edge E0: BUSY rises after E0.
- Normal operation:
  - Iterations run on edges E1..EWIDTH.
  - FIX edge E(WIDTH+1) writes HI/LO; DONE is high and BUSY low for the following cycle.
  - Latency from accept to DONE: WIDTH+1 edges (33 for WIDTH=32).
- Divide by zero: FIX at E1, so DONE is high the cycle after E1.
- START while BUSY is ignored. START in the DONE cycle is accepted, giving back-to-back operation.
- DONE is never high for more than one consecutive cycle unless a new operation finishes again.

## Structure
- Package mdu_pkg holds:
  - the FUNC code constants;
  - the state encoding (IDLE/MUL/DIV/FIX);
  - the WIDTH ≥ 4 check.
- One sub-module, mdu_iter_step: combinational single-bit shift-add / restoring-subtract step, parametrised by WIDTH. The parent holds all registers and the FSM.

## Test plan
All values for WIDTH=32.
- MULTU RS=0xFFFFFFFF, RT=2 → DONE 33 edges after accept; HI=0x00000001, LO=0xFFFFFFFE.
- MULT RS=−3, RT=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIVU 15/4 → HI=3, LO=3.
- DIV RS=−7, RT=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, DIV_ZERO=0.
- DIV RS=9, RT=0 → DONE the cycle after E1; HI=9, LO=0xFFFFFFFF, DIV_ZERO=1. The next MULT clears DIV_ZERO.
- Handshake:
  - START with a different FUNC while BUSY → ignored; the original result is unchanged.
  - START in the DONE cycle → second operation accepted.
  - MTHI RS=0x1234 in IDLE → HI=0x1234 next edge, no DONE.
- RSTN pulsed low mid-MULT → BUSY=0, HI=LO=0 immediately. No DONE after release. A fresh MULTU 6×7 then gives LO=42.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: R-type function
// codes, FSM state encoding and the minimum supported operand width.
package mdu_pkg;

  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  localparam int MIN_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // Elaboration-time guard used by the top level.
  function automatic bit width_ok(int w);
    return w >= MIN_WIDTH;
  endfunction

  // True for the four codes that start an iterative operation.
  function automatic logic is_md_op(logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) ||
           (f == FUNC_DIV)  || (f == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// The 2*WIDTH accumulator is {upper, lower}:
//   multiply: upper = partial product, lower = remaining multiplier bits
//   divide:   upper = partial remainder, lower = dividend bits / quotient
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Shift-add (multiply) or restoring trial-subtract (divide) for one bit.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path
    // (defaults first, then overrides) so no latch can be inferred.
    acc_out = acc_in;
    add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} +
              (acc_in[0] ? {1'b0, operand} : '0);
    rem_sh  = acc_in[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, operand};
    if (div_mode) begin
      if (diff[WIDTH]) begin
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_out = {add_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle on operand magnitudes; a final FIX cycle applies signs
// and writes HI/LO, followed by a one-cycle DONE pulse.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  generate
    if (!width_ok(WIDTH)) begin : g_width_chk
      $error("mult_div_unit: WIDTH must be at least 4");
    end
  endgenerate

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   operand;
  logic [CW-1:0]      count;
  logic               neg_lo;     // negate product / quotient in FIX
  logic               neg_hi;     // negate remainder in FIX
  logic               fix_div;    // FIX writes quotient/remainder, not product

  logic               accept;
  logic               op_div;
  logic               op_signed;
  logic               rt_zero;
  logic               last_iter;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept    = (state == ST_IDLE) && start && is_md_op(func);
  assign op_div    = (func == FUNC_DIV)  || (func == FUNC_DIVU);
  assign op_signed = (func == FUNC_MULT) || (func == FUNC_DIV);
  assign rt_zero   = (rt_val == '0);
  assign last_iter = (count == CW'(WIDTH - 1));

  // Magnitudes for signed ops; the most-negative value maps to itself,
  // which read as unsigned is exactly its magnitude.
  assign rs_mag = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // Sign correction applied on the FIX cycle.
  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state == ST_DIV),
    .acc_in   (acc),
    .operand  (operand),
    .acc_out  (acc_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and BUSY decode.
  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_div && rt_zero) begin
            state_nxt = ST_FIX;
          end else if (op_div) begin
            state_nxt = ST_DIV;
          end else begin
            state_nxt = ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_iter) begin
          state_nxt = ST_FIX;
        end
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, FIX write-back and MTHI/MTLO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator and operand are reset too; a reset mid-operation
      // must leave nothing observable behind, and it keeps simulation X-free.
      acc      <= '0;
      operand  <= '0;
      count    <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      fix_div  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      done <= 1'b0;
      if (accept) begin
        count    <= '0;
        fix_div  <= op_div;
        div_zero <= op_div && rt_zero;
        if (op_div && rt_zero) begin
          // Preloaded so the unsigned FIX path yields HI = dividend, LO = ones.
          acc     <= {rs_val, {WIDTH{1'b1}}};
          operand <= '0;
          neg_lo  <= 1'b0;
          neg_hi  <= 1'b0;
        end else if (op_div) begin
          acc     <= {{WIDTH{1'b0}}, rs_mag};
          operand <= rt_mag;
          neg_lo  <= op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          neg_hi  <= op_signed && rs_val[WIDTH-1];
        end else begin
          acc     <= {{WIDTH{1'b0}}, rt_mag};
          operand <= rs_mag;
          neg_lo  <= op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          neg_hi  <= 1'b0;
        end
      end else if ((state == ST_MUL) || (state == ST_DIV)) begin
        acc   <= acc_step;
        count <= count + 1'b1;
      end else if (state == ST_FIX) begin
        done <= 1'b1;
        if (fix_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end

      if ((state == ST_IDLE) && start && (func == FUNC_MTHI)) begin
        hi <= rs_val;
      end
      if ((state == ST_IDLE) && start && (func == FUNC_MTLO)) begin
        lo <= rs_val;
      end
    end
  end

endmodule
